sdram_axi_master: RTL and testbench
===================================

// Module: sdram_axi_master
// PURPOSE
//  AXI4 master bridge: accepts the simple RAM request port (wr strobes, rd, len, addr, data,
//  accept/ack) as a target and issues AXI4 INCR bursts toward an AXI4 slave such as the SDRAM
//  AXI front end. Lets native-port clients (DMA, test engines) reach SDRAM over AXI.
//  One outstanding burst at a time; write has priority over read when both request in IDLE.
// PARAMETERS
//  AXI_ID     4'h0   constant ID driven on awid/arid
//  BURST_TYPE 2'b01  axburst driven (INCR); awsize/arsize fixed 3'b010 (32-bit)
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   asynchronous reset, active-high
//  req_wr_i         in   4   byte strobes; !=0 = write beat valid
//  req_rd_i         in   1   read burst request
//  req_len_i        in   8   beats-1; sampled on first beat of a burst only
//  req_addr_i       in   32  start address; sampled on first beat only
//  req_wdata_i      in   32  write beat data
//  req_accept_o     out  1   beat/request taken this cycle
//  req_ack_o        out  1   one pulse per completed beat
//  req_error_o      out  1   qualifies req_ack_o: slave returned SLVERR/DECERR
//  req_rdata_o      out  32  read data, valid with req_ack_o
//  axi_aw{valid,addr,id,len,burst,size} out; axi_awready_i in
//  axi_w{valid,data,strb,last} out; axi_wready_i in
//  axi_bvalid_i, axi_bresp_i[1:0], axi_bid_i[3:0] in; axi_bready_o out
//  axi_ar{valid,addr,id,len,burst,size} out; axi_arready_i in
//  axi_rvalid_i, axi_rdata_i[31:0], axi_rresp_i[1:0], axi_rid_i[3:0], axi_rlast_i in; axi_rready_o out
// BEHAVIOUR
//  Reset: state IDLE; all AXI valids, bready, rready, req_accept_o, req_ack_o, req_error_o = 0;
//   req_rdata_o = 0; beat counter, len, addr, data/strb holding regs = 0. Reset mid-burst
//   abandons the burst (no ack, no AXI completion).
//  FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
//  IDLE: req_accept_o = (req_wr_i!=0)|req_rd_i. Write wins if both. On write: latch addr,
//   len, strb, wdata, beat_cnt=0 -> WR_ADDR. On read: latch addr, len -> RD_ADDR.
//  WR_ADDR: awvalid=1, awaddr/awlen from regs; hold until awready -> WR_DATA. No W before AW.
//  WR_DATA: wvalid=1 while holding reg full; wlast = (beat_cnt==len). On wready:
//   non-last beat -> req_ack_o pulse next cycle (error=0), beat_cnt+1; last -> WR_RESP.
//   req_accept_o = (req_wr_i!=0) & (hold empty | (wready & !wlast)) -> back-to-back beats at
//   1 beat/clk. No further beats accepted once last beat is held.
//  WR_RESP: bready=1; on bvalid: req_ack_o=1 (last-beat ack), req_error_o=bresp[1] -> IDLE.
//  RD_ADDR: arvalid=1 until arready -> RD_DATA, beat_cnt=0.
//  RD_DATA: rready=1 (requester cannot backpressure acks). Each rvalid: registered
//   req_ack_o=1, req_rdata_o=rdata, req_error_o=rresp[1]; beat_cnt+1.
//   Burst ends on rlast or beat_cnt==len, whichever first -> IDLE; if they disagree,
//   that final ack carries req_error_o=1.
//  Valids, once raised, stay high with stable payload until handshake (AXI rule).
//  req_rd_i/req_wr_i outside the states above: req_accept_o=0, no side effects.
//  Ack latency: write non-last beat 1 clk after W handshake; last beat 1 clk after B;
//   read beat 1 clk after R handshake. req_ack_o never asserted 2 cycles for one beat.
//  Widths: beat_cnt 8 bits; len 255 = 256 beats, no wrap beyond.
// TESTING
//  1. Single write addr=0x100 len=0 strb=0xF data=0xDEADBEEF; slave ready at once -> AW len=0,
//     W wlast=1, 1 ack after B OKAY, error=0; total 4 clks IDLE->IDLE.
//  2. Write len=3, wready toggling 1/0 -> 4 W beats in order, wlast only on 4th, 4 acks,
//     last after B; bresp=2'b10 -> final ack error=1.
//  3. Read addr=0x2000 len=7, R beats with gaps -> arlen=7, 8 acks, rdata in order, back to IDLE.
//  4. Read len=3 but slave asserts rlast on beat 2 -> 2 acks, 2nd with error=1, state IDLE.
//  5. req_wr_i and req_rd_i asserted same cycle in IDLE -> write burst first, read accepted
//     only after write B completes.
//  6. rst_i pulsed in WR_DATA with awready held 0 then 1 -> all valids 0 same cycle, no ack,
//     next request starts clean AW.

Source files
------------

// File: rtl/sdram_axi_master_if.sv
// Bundle of the simple RAM request port and the AXI4 master bus for sdram_axi_master.
// The master modport is the bridge's view; slave is the requester/AXI-slave side.
interface sdram_axi_master_if;
   // Native request port
   logic [3:0]  req_wr;
   logic        req_rd;
   logic [7:0]  req_len;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_accept;
   logic        req_ack;
   logic        req_error;
   logic [31:0] req_rdata;

   // AXI4 write address/data/response channels
   logic        axi_awvalid;
   logic [31:0] axi_awaddr;
   logic [3:0]  axi_awid;
   logic [7:0]  axi_awlen;
   logic [1:0]  axi_awburst;
   logic [2:0]  axi_awsize;
   logic        axi_awready;
   logic        axi_wvalid;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wlast;
   logic        axi_wready;
   logic        axi_bvalid;
   logic [1:0]  axi_bresp;
   logic [3:0]  axi_bid;
   logic        axi_bready;

   // AXI4 read address/data channels
   logic        axi_arvalid;
   logic [31:0] axi_araddr;
   logic [3:0]  axi_arid;
   logic [7:0]  axi_arlen;
   logic [1:0]  axi_arburst;
   logic [2:0]  axi_arsize;
   logic        axi_arready;
   logic        axi_rvalid;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic [3:0]  axi_rid;
   logic        axi_rlast;
   logic        axi_rready;

   modport master (
      input  req_wr, req_rd, req_len, req_addr, req_wdata,
      output req_accept, req_ack, req_error, req_rdata,
      output axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awburst, axi_awsize,
      input  axi_awready,
      output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
      input  axi_wready,
      input  axi_bvalid, axi_bresp, axi_bid,
      output axi_bready,
      output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arburst, axi_arsize,
      input  axi_arready,
      input  axi_rvalid, axi_rdata, axi_rresp, axi_rid, axi_rlast,
      output axi_rready
   );

   modport slave (
      output req_wr, req_rd, req_len, req_addr, req_wdata,
      input  req_accept, req_ack, req_error, req_rdata,
      input  axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awburst, axi_awsize,
      output axi_awready,
      input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
      output axi_wready,
      output axi_bvalid, axi_bresp, axi_bid,
      input  axi_bready,
      input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arburst, axi_arsize,
      output axi_arready,
      output axi_rvalid, axi_rdata, axi_rresp, axi_rid, axi_rlast,
      input  axi_rready
   );
endinterface

// File: rtl/sdram_axi_master.sv
// Bridge from the simple RAM request port to single-outstanding AXI4 INCR bursts.
// Write wins over read when both request in IDLE; one write beat is buffered in a holding reg.
module sdram_axi_master #(
   parameter logic [3:0] AXI_ID     = 4'h0,
   parameter logic [1:0] BURST_TYPE = 2'b01
) (
   input  logic               clk_i,
   input  logic               rst_i,
   sdram_axi_master_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_DATA = 3'd5
   } state_t;

   state_t      state_r,  state_s;
   logic [31:0] addr_r,   addr_s;
   logic [7:0]  len_r,    len_s;
   logic [7:0]  cnt_r,    cnt_s;
   logic [3:0]  strb_r,   strb_s;
   logic [31:0] wdata_r,  wdata_s;
   logic        full_r,   full_s;
   logic        ack_r,    ack_s;
   logic        err_r,    err_s;
   logic [31:0] rdata_r,  rdata_s;

   logic        accept_s;
   logic        at_len_s;
   logic        w_hs_s;
   logic        wr_req_s;
   logic        unused_s;

   assign at_len_s = (cnt_r == len_r);
   assign wr_req_s = (bus.req_wr != 4'h0);
   assign w_hs_s   = (state_r == ST_WR_DATA) && full_r && bus.axi_wready;

   // Next-state and datapath update for the burst FSM
   always_comb begin
      state_s  = state_r;
      addr_s   = addr_r;
      len_s    = len_r;
      cnt_s    = cnt_r;
      strb_s   = strb_r;
      wdata_s  = wdata_r;
      full_s   = full_r;
      ack_s    = 1'b0;
      err_s    = 1'b0;
      rdata_s  = rdata_r;
      accept_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (wr_req_s) begin
               accept_s = 1'b1;
               addr_s   = bus.req_addr;
               len_s    = bus.req_len;
               strb_s   = bus.req_wr;
               wdata_s  = bus.req_wdata;
               full_s   = 1'b1;
               cnt_s    = 8'd0;
               state_s  = ST_WR_ADDR;
            end else if (bus.req_rd) begin
               accept_s = 1'b1;
               addr_s   = bus.req_addr;
               len_s    = bus.req_len;
               cnt_s    = 8'd0;
               state_s  = ST_RD_ADDR;
            end else begin
               state_s  = ST_IDLE;
            end
         end

         ST_WR_ADDR: begin
            if (bus.axi_awready) begin
               state_s = ST_WR_DATA;
            end else begin
               state_s = ST_WR_ADDR;
            end
         end

         ST_WR_DATA: begin
            // Non-last beats are acked on their W handshake; the last waits for B.
            if (w_hs_s) begin
               full_s = 1'b0;
               if (at_len_s) begin
                  state_s = ST_WR_RESP;
               end else begin
                  ack_s = 1'b1;
                  cnt_s = cnt_r + 8'd1;
               end
            end else begin
               full_s = full_r;
            end
            accept_s = wr_req_s && (!full_r || (w_hs_s && !at_len_s));
            if (accept_s) begin
               strb_s  = bus.req_wr;
               wdata_s = bus.req_wdata;
               full_s  = 1'b1;
            end else begin
               strb_s  = strb_r;
            end
         end

         ST_WR_RESP: begin
            if (bus.axi_bvalid) begin
               ack_s   = 1'b1;
               err_s   = bus.axi_bresp[1];
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WR_RESP;
            end
         end

         ST_RD_ADDR: begin
            if (bus.axi_arready) begin
               cnt_s   = 8'd0;
               state_s = ST_RD_DATA;
            end else begin
               state_s = ST_RD_ADDR;
            end
         end

         ST_RD_DATA: begin
            // An rlast that disagrees with the requested length flags the final beat.
            if (bus.axi_rvalid) begin
               ack_s   = 1'b1;
               rdata_s = bus.axi_rdata;
               err_s   = bus.axi_rresp[1] || (bus.axi_rlast != at_len_s);
               cnt_s   = cnt_r + 8'd1;
               if (bus.axi_rlast || at_len_s) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_RD_DATA;
               end
            end else begin
               state_s = ST_RD_DATA;
            end
         end

         default: begin
            state_s = ST_IDLE;
            full_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any burst in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         addr_r  <= 32'd0;
         len_r   <= 8'd0;
         cnt_r   <= 8'd0;
         strb_r  <= 4'h0;
         wdata_r <= 32'd0;
         full_r  <= 1'b0;
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
         rdata_r <= 32'd0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         len_r   <= len_s;
         cnt_r   <= cnt_s;
         strb_r  <= strb_s;
         wdata_r <= wdata_s;
         full_r  <= full_s;
         ack_r   <= ack_s;
         err_r   <= err_s;
         rdata_r <= rdata_s;
      end
   end

   assign bus.req_accept  = accept_s;
   assign bus.req_ack     = ack_r;
   assign bus.req_error   = err_r;
   assign bus.req_rdata   = rdata_r;

   assign bus.axi_awvalid = (state_r == ST_WR_ADDR);
   assign bus.axi_awaddr  = addr_r;
   assign bus.axi_awid    = AXI_ID;
   assign bus.axi_awlen   = len_r;
   assign bus.axi_awburst = BURST_TYPE;
   assign bus.axi_awsize  = 3'b010;

   assign bus.axi_wvalid  = (state_r == ST_WR_DATA) && full_r;
   assign bus.axi_wdata   = wdata_r;
   assign bus.axi_wstrb   = strb_r;
   assign bus.axi_wlast   = at_len_s;
   assign bus.axi_bready  = (state_r == ST_WR_RESP);

   assign bus.axi_arvalid = (state_r == ST_RD_ADDR);
   assign bus.axi_araddr  = addr_r;
   assign bus.axi_arid    = AXI_ID;
   assign bus.axi_arlen   = len_r;
   assign bus.axi_arburst = BURST_TYPE;
   assign bus.axi_arsize  = 3'b010;
   assign bus.axi_rready  = (state_r == ST_RD_DATA);

   // IDs and the low response bits carry nothing this bridge acts on
   assign unused_s = ^{bus.axi_bid, bus.axi_rid, bus.axi_bresp[0], bus.axi_rresp[0]};

endmodule

// File: tb/tb_sdram_axi_master.sv
// Self-checking bench for sdram_axi_master: vector table of bursts, scoreboard of expected acks,
// plus hand-written sequences for write/read collision and reset mid-burst.
module tb_sdram_axi_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fails = 0;

   always #5 clk = ~clk;

   sdram_axi_master_if bus ();

   sdram_axi_master #(.AXI_ID(4'h0), .BURST_TYPE(2'b01)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  resp;
      logic        pattern;     // write: toggle wready; read: gaps on AR/R
      int          early;       // read: beat index carrying rlast, -1 = normal
      int          exp_cycles;  // write: IDLE->IDLE clocks, 0 = unchecked
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wr_data(input int i);
      return 32'hDEADBEEF ^ (32'(i) * 32'h00010001);
   endfunction

   function automatic logic [3:0] wr_strb(input int i);
      return (i % 2 == 1) ? 4'h3 : 4'hF;
   endfunction

   function automatic logic [31:0] rd_data(input logic [31:0] addr, input int i);
      return (addr << 4) + 32'h5A000000 + 32'(i);
   endfunction

   // Scoreboard: every ack pops one expectation in order
   always @(negedge clk) begin
      if (bus.req_ack) begin
         chk("sb_nonempty_on_ack", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_error", 32'(bus.req_error), 32'(e.err));
            if (e.is_rd) chk("ack_rdata", bus.req_rdata, e.data);
         end
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] resp,
                           input logic toggle, input logic rd_too, output int cycles);
      int   sb_n = 0;
      int   w_n = 0;
      int   cyc = 0;
      int   exp_n = int'(len) + 1;
      logic aw_done = 1'b0;
      logic done = 1'b0;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         bus.req_wr      = (sb_n < exp_n) ? wr_strb(sb_n) : 4'h0;
         bus.req_wdata   = wr_data(sb_n);
         bus.req_addr    = addr;
         bus.req_len     = len;
         bus.req_rd      = rd_too;
         bus.axi_awready = 1'b1;
         bus.axi_wready  = toggle ? (cyc % 2 == 1) : 1'b1;
         bus.axi_bvalid  = (w_n == exp_n);
         bus.axi_bresp   = resp;
         bus.axi_bid     = 4'h0;
         #1;
         chk("ar_during_wr", 32'(bus.axi_arvalid), 32'd0);
         if (bus.req_accept) begin
            chk("accept_has_wr", 32'(bus.req_wr != 4'h0), 32'd1);
            sb.push_back('{1'b0, 32'd0, (sb_n == exp_n - 1) ? resp[1] : 1'b0});
            sb_n++;
         end
         if (bus.axi_awvalid && !aw_done) begin
            chk("awaddr", bus.axi_awaddr, addr);
            chk("awlen", 32'(bus.axi_awlen), 32'(len));
            chk("awburst_size_id", 32'({bus.axi_awburst, bus.axi_awsize, bus.axi_awid}), 32'({2'b01, 3'b010, 4'h0}));
            aw_done = 1'b1;
         end
         if (bus.axi_wvalid) chk("w_before_aw_hs", 32'(aw_done && !bus.axi_awvalid), 32'd1);
         if (bus.axi_wvalid && bus.axi_wready) begin
            chk("wdata", bus.axi_wdata, wr_data(w_n));
            chk("wstrb", 32'(bus.axi_wstrb), 32'(wr_strb(w_n)));
            chk("wlast", 32'(bus.axi_wlast), 32'(w_n == exp_n - 1));
            w_n++;
         end
         if (bus.axi_bvalid && bus.axi_bready) done = 1'b1;
         cyc++;
      end
      chk("wr_completed", 32'(done), 32'd1);
      cycles = cyc;
      @(negedge clk);
      chk("wr_final_ack", 32'(bus.req_ack), 32'd1);
      bus.req_wr     = 4'h0;
      bus.req_rd     = 1'b0;
      bus.axi_bvalid = 1'b0;
      bus.axi_wready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] resp,
                          input logic gaps, input int early);
      int   rb = 0;
      int   cyc = 0;
      int   last_idx = (early >= 0) ? early : int'(len);
      logic accepted = 1'b0;
      logic ar_done = 1'b0;
      logic done = 1'b0;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         bus.req_rd      = !accepted;
         bus.req_wr      = 4'h0;
         bus.req_addr    = addr;
         bus.req_len     = len;
         bus.axi_arready = gaps ? (cyc >= 3) : 1'b1;
         bus.axi_rvalid  = ar_done && (gaps ? (cyc % 3 != 0) : 1'b1);
         bus.axi_rdata   = rd_data(addr, rb);
         bus.axi_rlast   = (rb == last_idx);
         bus.axi_rresp   = resp;
         bus.axi_rid     = 4'h0;
         #1;
         chk("aw_w_during_rd", 32'({bus.axi_awvalid, bus.axi_wvalid}), 32'd0);
         if (bus.req_accept) accepted = 1'b1;
         if (bus.axi_arvalid && bus.axi_arready && !ar_done) begin
            chk("araddr", bus.axi_araddr, addr);
            chk("arlen", 32'(bus.axi_arlen), 32'(len));
            chk("arburst_size_id", 32'({bus.axi_arburst, bus.axi_arsize, bus.axi_arid}), 32'({2'b01, 3'b010, 4'h0}));
            ar_done = 1'b1;
         end
         if (bus.axi_rvalid && bus.axi_rready) begin
            sb.push_back('{1'b1, rd_data(addr, rb), resp[1] | (bus.axi_rlast && rb != int'(len))});
            rb++;
            if (bus.axi_rlast) done = 1'b1;
         end
         cyc++;
      end
      chk("rd_completed", 32'(done), 32'd1);
      @(negedge clk);
      bus.req_rd      = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rlast   = 1'b0;
      bus.axi_arready = 1'b0;
      chk("rd_beats", 32'(rb), 32'(last_idx + 1));
   endtask

   initial begin
      vec_t vecs[8];
      int   cyc;

      vecs[0] = '{1'b1, 32'h0000_0100, 8'd0,   2'b00, 1'b0, -1, 4};
      vecs[1] = '{1'b1, 32'h0000_0200, 8'd3,   2'b10, 1'b1, -1, 0};
      vecs[2] = '{1'b0, 32'h0000_2000, 8'd7,   2'b00, 1'b1, -1, 0};
      vecs[3] = '{1'b0, 32'h0000_3000, 8'd3,   2'b00, 1'b0,  1, 0};
      vecs[4] = '{1'b1, 32'h0001_0000, 8'd255, 2'b01, 1'b0, -1, 0};
      vecs[5] = '{1'b0, 32'h0002_0000, 8'd255, 2'b00, 1'b0, -1, 0};
      vecs[6] = '{1'b0, 32'h0000_4000, 8'd1,   2'b11, 1'b1, -1, 0};
      vecs[7] = '{1'b1, 32'h0000_5000, 8'd2,   2'b11, 1'b1, -1, 0};

      bus.req_wr = 4'h0;       bus.req_rd = 1'b0;       bus.req_len = 8'd0;
      bus.req_addr = 32'd0;    bus.req_wdata = 32'd0;
      bus.axi_awready = 1'b0;  bus.axi_wready = 1'b0;
      bus.axi_bvalid = 1'b0;   bus.axi_bresp = 2'b00;   bus.axi_bid = 4'h0;
      bus.axi_arready = 1'b0;  bus.axi_rvalid = 1'b0;   bus.axi_rdata = 32'd0;
      bus.axi_rresp = 2'b00;   bus.axi_rid = 4'h0;      bus.axi_rlast = 1'b0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valids", 32'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready}), 32'd0);
      chk("rst_accept_ack_err", 32'({bus.req_accept, bus.req_ack, bus.req_error}), 32'd0);
      chk("rst_rdata", bus.req_rdata, 32'd0);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].len, vecs[i].resp, vecs[i].pattern, 1'b0, cyc);
            if (vecs[i].exp_cycles != 0) chk("wr_idle_to_idle_clks", 32'(cyc), 32'(vecs[i].exp_cycles));
         end else begin
            do_read(vecs[i].addr, vecs[i].len, vecs[i].resp, vecs[i].pattern, vecs[i].early);
         end
      end

      // Write and read requested together: write burst runs first, read follows B
      do_write(32'h0000_6000, 8'd1, 2'b00, 1'b0, 1'b1, cyc);
      do_read(32'h0000_7000, 8'd2, 2'b00, 1'b0, -1);

      // Reset in WR_DATA abandons the burst with no ack
      @(negedge clk);
      bus.req_wr = 4'hF; bus.req_addr = 32'h0000_0300; bus.req_len = 8'd2;
      bus.req_wdata = 32'h1234_5678; bus.axi_awready = 1'b0; bus.axi_wready = 1'b0;
      #1;
      chk("rstseq_accept", 32'(bus.req_accept), 32'd1);
      @(negedge clk);
      bus.req_wr = 4'h0;
      #1;
      chk("rstseq_aw_held", 32'(bus.axi_awvalid), 32'd1);
      @(negedge clk);
      bus.axi_awready = 1'b1;
      @(negedge clk);
      bus.axi_awready = 1'b0;
      #1;
      chk("rstseq_in_wr_data", 32'({bus.axi_awvalid, bus.axi_wvalid}), 32'b01);
      rst = 1'b1;
      #1;
      chk("rstseq_valids_low", 32'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready}), 32'd0);
      chk("rstseq_no_ack", 32'({bus.req_ack, bus.req_error, bus.req_accept}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstseq_idle_after", 32'({bus.axi_awvalid, bus.axi_wvalid, bus.req_ack}), 32'd0);
      do_write(32'h0000_0400, 8'd0, 2'b00, 1'b0, 1'b0, cyc);
      chk("rstseq_clean_clks", 32'(cyc), 32'd4);

      repeat (5) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
